wide_add_sequencer: RTL and testbench
=====================================

// Module: wide_add_sequencer
// PURPOSE
//  Drives the 8-bit Brent-Kung adder slice and consumes its output: accepts one WIDTH-bit add
//  request, issues it to the slice as WIDTH/SLICE beats starting at the LSB, and ripples the
//  carry between beats. Collects the slice sums into one WIDTH-bit result with carry-out.
//  Sits between operand producers and the adder slice, so the datapath can add wide operands
//  with one narrow adder.
// PARAMETERS
//  WIDTH  32  operand/result width; must be a nonzero multiple of SLICE
//  SLICE   8  adder slice width; must match the adder instance
//  BEATS  WIDTH/SLICE  localparam, slices per operation; beat counter width is clog2(BEATS), min 1
// PORTS
//  clk           in   1      clock, all logic on rising edge
//  reset         in   1      synchronous reset, active-high
//  iValid        in   1      request valid; transfers on the edge where iValid & oAccept
//  oAccept       out  1      ready for a request; high only in IDLE
//  iCarryIn      in   1      carry into bit 0; sampled at transfer
//  iX            in   WIDTH  operand X; sampled at transfer
//  iY            in   WIDTH  operand Y; sampled at transfer
//  oZ            out  WIDTH  sum, registered; held until the next completion
//  oCarryOut     out  1      carry out of bit WIDTH-1, registered; held with oZ
//  oValid        out  1      one-cycle pulse: oZ/oCarryOut updated this cycle
//  oAddValid     out  1      to adder iValid; one-cycle pulse per beat
//  oAddCarryIn   out  1      to adder iCarryIn
//  oAddX         out  SLICE  to adder iX: beat slice of the latched X
//  oAddY         out  SLICE  to adder iY: beat slice of the latched Y
//  iAddZ         in   SLICE  from adder oZ
//  iAddCarryOut  in   1      from adder oCarryOut
//  iAddReady     in   1      from adder oReady; slice result valid this cycle
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, beat=0, oAccept=1, oValid=0, oZ=0, oCarryOut=0.
//   - oAddValid=0; oAddX, oAddY and oAddCarryIn = 0.
//  FSM transitions:
//   - IDLE: on iValid, latch iX, iY and iCarryIn into opX, opY and chainC; clear beat and the
//     partial sum acc; go to ISSUE.
//   - ISSUE: oAddValid=1 for exactly one cycle. Drive oAddX = opX[beat*SLICE +: SLICE],
//     oAddY likewise, oAddCarryIn = chainC. Go to WAIT.
//   - WAIT: wait for iAddReady; there is no timeout. On iAddReady:
//     acc[beat*SLICE +: SLICE] <= iAddZ and chainC <= iAddCarryOut.
//     If beat == BEATS-1, go to DONE; otherwise beat <= beat+1 and go to ISSUE.
//   - DONE: oZ <= acc and oCarryOut <= chainC, both registered; oValid=1 for one cycle;
//     go to IDLE.
//  Ports and timing rules:
//   - oAddX, oAddY and oAddCarryIn are registered and hold their value outside ISSUE.
//   - Latency: if L is the adder's iValid-to-oReady delay in cycles, oValid rises
//     BEATS*(1+L)+1 cycles after the transfer edge.
//   - Throughput: one request per BEATS*(1+L)+2 cycles.
//   - iValid while oAccept=0 is ignored; the producer must hold it until accepted.
//   - iAddReady is ignored in IDLE, ISSUE and DONE. This covers stale responses still in flight
//     when reset is asserted.
//   - Only one beat is outstanding at a time; carries propagate strictly between beats.
//  Reset during an operation:
//   - On the next edge, return to IDLE with reset values and discard the partial acc.
//   - No oValid is produced for the aborted request.
// CONFIGURATION
//  WIDE_ADD_SUB_EN:
//   - Defined: adds input port iSub (1 bit), sampled at transfer. iSub=1 latches opY=~iY and
//     chainC=1, ignoring iCarryIn, so oZ = iX - iY mod 2^WIDTH. oCarryOut=1 means no borrow.
//     iSub=0 behaves as in the undefined case.
//   - Undefined: the iSub port is absent; addition only.
// TESTING (WIDTH=32, SLICE=8, adder model with L=2)
//  1. X=0x000000FF, Y=0x00000001, cin=0 -> oZ=0x00000100, oCarryOut=0;
//     oValid exactly 13 cycles after transfer.
//  2. X=0xFFFFFFFF, Y=0x00000001, cin=0 -> oZ=0x00000000, oCarryOut=1
//     (carry ripples through all 4 beats).
//  3. X=0, Y=0, cin=1 -> oZ=0x00000001, oCarryOut=0;
//     beat 0 shows oAddCarryIn=1, beats 1-3 show 0.
//  4. Request A=(0x12345678, 0x11111111) held with request B valid behind it
//     -> oAccept=0 through A; oZ=0x23456789; B accepted only after A's DONE; both results correct.
//  5. reset for 1 cycle during WAIT of beat 2, with the adder's oReady arriving after reset
//     -> oValid never pulses, oZ=0, oAccept=1. Next request 0x1+0x1 -> 0x2.
//  6. WIDE_ADD_SUB_EN: X=5, Y=7, iSub=1 -> oZ=0xFFFFFFFE, oCarryOut=0;
//     X=7, Y=5 -> oZ=0x00000002, oCarryOut=1.

Source files
------------

// File: rtl/wide_add_sequencer.sv
// Sequences a WIDTH-bit add through one SLICE-bit adder, LSB beat first, rippling carry between beats.
// Optional WIDE_ADD_SUB_EN adds iSub for X - Y via inverted Y and forced carry-in.
module wide_add_sequencer #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
`ifdef WIDE_ADD_SUB_EN
  input  logic             iSub,
`endif
  input  logic             iValid,
  output logic             oAccept,
  input  logic             iCarryIn,
  input  logic [WIDTH-1:0] iX,
  input  logic [WIDTH-1:0] iY,
  output logic [WIDTH-1:0] oZ,
  output logic             oCarryOut,
  output logic             oValid,
  output logic             oAddValid,
  output logic             oAddCarryIn,
  output logic [SLICE-1:0] oAddX,
  output logic [SLICE-1:0] oAddY,
  input  logic [SLICE-1:0] iAddZ,
  input  logic             iAddCarryOut,
  input  logic             iAddReady
);
  localparam int BEATS = WIDTH / SLICE;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state, stateNext;
  logic [BW-1:0]    beat;
  logic [WIDTH-1:0] opX, opY, acc;
  logic             chainC;
  logic             sub;
  logic [WIDTH-1:0] yIn;
  logic             cIn;
  logic             lastBeat;

`ifdef WIDE_ADD_SUB_EN
  assign sub = iSub;
`else
  assign sub = 1'b0;
`endif

  // Subtraction is X + ~Y + 1, so the inversion and forced carry happen at latch time.
  assign yIn      = sub ? ~iY : iY;
  assign cIn      = sub ? 1'b1 : iCarryIn;
  assign lastBeat = (beat == BW'(BEATS - 1));

  always_comb begin
    stateNext = state;
    oAccept   = (state == IDLE);
    oAddValid = (state == ISSUE);
    case (state)
      IDLE:  if (iValid) stateNext = ISSUE;
      ISSUE: stateNext = WAIT;
      WAIT:  if (iAddReady) stateNext = lastBeat ? DONE : ISSUE;
      DONE:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      beat        <= '0;
      opX         <= '0;
      opY         <= '0;
      acc         <= '0;
      chainC      <= 1'b0;
      oZ          <= '0;
      oCarryOut   <= 1'b0;
      oValid      <= 1'b0;
      oAddX       <= '0;
      oAddY       <= '0;
      oAddCarryIn <= 1'b0;
    end else begin
      state  <= stateNext;
      oValid <= 1'b0;
      case (state)
        IDLE: if (iValid) begin
          opX         <= iX;
          opY         <= yIn;
          chainC      <= cIn;
          beat        <= '0;
          acc         <= '0;
          // Slice drive is registered, so beat 0 is loaded on the way into ISSUE.
          oAddX       <= iX[SLICE-1:0];
          oAddY       <= yIn[SLICE-1:0];
          oAddCarryIn <= cIn;
        end
        WAIT: if (iAddReady) begin
          acc[int'(beat)*SLICE +: SLICE] <= iAddZ;
          chainC                         <= iAddCarryOut;
          if (!lastBeat) begin
            beat        <= beat + BW'(1);
            oAddX       <= opX[(int'(beat)+1)*SLICE +: SLICE];
            oAddY       <= opY[(int'(beat)+1)*SLICE +: SLICE];
            oAddCarryIn <= iAddCarryOut;
          end
        end
        DONE: begin
          oZ        <= acc;
          oCarryOut <= chainC;
          oValid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer: directed plus random adds against a plain-arithmetic reference,
// with a fixed-latency slice adder model (L cycles from iValid to oReady).
module tb_wide_add_sequencer;
  localparam int W = 32, S = 8, L = 2;
  localparam int BEATS = W / S;
  localparam int LAT = BEATS * (1 + L) + 1;
  localparam int BUDGET = 200;

  logic         clk = 1'b0, reset = 1'b1;
  logic         iValid = 1'b0, iCarryIn = 1'b0, iSub = 1'b0;
  logic [W-1:0] iX = '0, iY = '0;
  logic [W-1:0] oZ;
  logic         oCarryOut, oValid, oAccept;
  logic         oAddValid, oAddCarryIn;
  logic [S-1:0] oAddX, oAddY, iAddZ;
  logic         iAddCarryOut, iAddReady;

  int checks = 0, errors = 0;
  bit cinLog[$];

  always #5 clk = ~clk;

  wide_add_sequencer #(.WIDTH(W), .SLICE(S)) dut (
    .clk(clk), .reset(reset),
`ifdef WIDE_ADD_SUB_EN
    .iSub(iSub),
`endif
    .iValid(iValid), .oAccept(oAccept), .iCarryIn(iCarryIn), .iX(iX), .iY(iY),
    .oZ(oZ), .oCarryOut(oCarryOut), .oValid(oValid),
    .oAddValid(oAddValid), .oAddCarryIn(oAddCarryIn), .oAddX(oAddX), .oAddY(oAddY),
    .iAddZ(iAddZ), .iAddCarryOut(iAddCarryOut), .iAddReady(iAddReady)
  );

  // Slice adder model: result and ready appear L cycles after the issue cycle; never reset,
  // so a response in flight at reset still arrives afterwards.
  logic [L-1:0] vp = '0;
  logic [S:0]   sp [L];
  initial for (int i = 0; i < L; i++) sp[i] = '0;
  always @(posedge clk) begin
    vp    <= {vp[L-2:0], oAddValid};
    sp[0] <= {1'b0, oAddX} + {1'b0, oAddY} + {{S{1'b0}}, oAddCarryIn};
    for (int i = 1; i < L; i++) sp[i] <= sp[i-1];
    if (oAddValid) cinLog.push_back(oAddCarryIn);
  end
  assign iAddReady    = vp[L-1];
  assign iAddZ        = sp[L-1][S-1:0];
  assign iAddCarryOut = sp[L-1][S];

  function automatic logic [W:0] refAdd(logic [W-1:0] x, logic [W-1:0] y, bit cin, bit sub);
    longint unsigned s;
    logic [W-1:0] yy;
    yy = sub ? ~y : y;
    s  = longint'(x) + longint'(yy) + longint'(sub ? 1 : cin);
    return s[W:0];
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(logic [W-1:0] x, logic [W-1:0] y, bit cin, bit sub);
    int n = 0;
    iX = x; iY = y; iCarryIn = cin; iSub = sub; iValid = 1'b1;
    cinLog.delete();
    while (!oAccept && n < BUDGET) begin @(posedge clk); #1; n++; end
    if (n >= BUDGET) chk("acceptTimeout", 1, 0);
    @(posedge clk); #1;
    iValid = 1'b0;
  endtask

  task automatic waitResult(output int n, output bit acceptSeen);
    n = 0; acceptSeen = 0;
    do begin
      @(posedge clk); #1; n++;
      if (!oValid && oAccept) acceptSeen = 1;
    end while (!oValid && n < BUDGET);
  endtask

  task automatic checkResult(string tag, logic [W-1:0] x, logic [W-1:0] y, bit cin, bit sub,
                             int n, bit acceptSeen);
    logic [W:0] e;
    e = refAdd(x, y, cin, sub);
    chk({tag, ".latency"}, 64'(n), 64'(LAT));
    chk({tag, ".oZ"}, 64'(oZ), 64'(e[W-1:0]));
    chk({tag, ".oCarryOut"}, 64'(oCarryOut), 64'(e[W]));
    chk({tag, ".acceptLow"}, 64'(acceptSeen), 0);
  endtask

  task automatic runOp(string tag, logic [W-1:0] x, logic [W-1:0] y, bit cin, bit sub);
    int n; bit a;
    send(x, y, cin, sub);
    waitResult(n, a);
    checkResult(tag, x, y, cin, sub, n, a);
    @(posedge clk); #1;
    chk({tag, ".pulse"}, 64'(oValid), 0);
  endtask

  initial begin
    int n; bit a; bit sub;
    logic [W-1:0] x, y;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst.oAccept", 64'(oAccept), 1);
    chk("rst.oValid", 64'(oValid), 0);
    chk("rst.oZ", 64'(oZ), 0);
    chk("rst.oCarryOut", 64'(oCarryOut), 0);
    chk("rst.oAddValid", 64'(oAddValid), 0);
    chk("rst.oAddX", 64'({oAddX, oAddY, oAddCarryIn}), 0);

    runOp("t1", 32'h000000FF, 32'h00000001, 0, 0);
    runOp("t2", 32'hFFFFFFFF, 32'h00000001, 0, 0);
    runOp("t3", 32'h0, 32'h0, 1, 0);
    chk("t3.beats", 64'(cinLog.size()), 64'(BEATS));
    for (int i = 0; i < BEATS && i < cinLog.size(); i++)
      chk($sformatf("t3.cin%0d", i), 64'(cinLog[i]), (i == 0) ? 1 : 0);

    // Back-to-back: B is presented while A is in flight.
    send(32'h12345678, 32'h11111111, 0, 0);
    iX = 32'h0F0F0F0F; iY = 32'hF0F0F0F1; iCarryIn = 0; iSub = 0; iValid = 1'b1;
    waitResult(n, a);
    checkResult("t4A", 32'h12345678, 32'h11111111, 0, 0, n, a);
    chk("t4A.z", 64'(oZ), 64'h23456789);
    @(posedge clk); #1;
    iValid = 1'b0;
    chk("t4B.taken", 64'(oAccept), 0);
    waitResult(n, a);
    checkResult("t4B", 32'h0F0F0F0F, 32'hF0F0F0F1, 0, 0, n, a);

    // Reset in the WAIT of beat 2; the in-flight slice response lands in IDLE.
    send(32'hAAAA5555, 32'h12341234, 1, 0);
    n = 0;
    while (cinLog.size() < 3 && n < BUDGET) begin @(posedge clk); #1; n++; end
    if (n >= BUDGET) chk("t5.beat2Timeout", 1, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    a = 0;
    for (int i = 0; i < 3 * LAT; i++) begin
      if (oValid) a = 1;
      @(posedge clk); #1;
    end
    chk("t5.noValid", 64'(a), 0);
    chk("t5.oZ", 64'(oZ), 0);
    chk("t5.oAccept", 64'(oAccept), 1);
    chk("t5.slices", 64'(cinLog.size()), 3);
    runOp("t5b", 32'h1, 32'h1, 0, 0);
    chk("t5b.z", 64'(oZ), 64'h2);

`ifdef WIDE_ADD_SUB_EN
    runOp("t6a", 32'd5, 32'd7, 0, 1);
    chk("t6a.z", 64'({oCarryOut, oZ}), 64'h0FFFFFFFE);
    runOp("t6b", 32'd7, 32'd5, 0, 1);
    chk("t6b.z", 64'({oCarryOut, oZ}), 64'h100000002);
`endif

    for (int k = 0; k < 24; k++) begin
      x = $urandom;
      y = $urandom;
      if (k % 6 == 0) y = ~x;
`ifdef WIDE_ADD_SUB_EN
      sub = 1'($urandom_range(0, 1));
`else
      sub = 0;
`endif
      runOp($sformatf("rnd%0d", k), x, y, 1'($urandom_range(0, 1)), sub);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
